// File: rtl/line_fill_buffer.sv
// Cache line refill engine: fetches a line one word at a time, critical word
// first with wrap-around, forwards the critical word, then holds the line until acked.
module line_fill_buffer #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     miss_req,
    input  logic [ADDR_W-1:0]        miss_addr,
    output logic                     busy,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic                     crit_valid,
    output logic [31:0]              crit_word,
    output logic                     fill_valid,
    output logic [ADDR_W-1:0]        fill_addr,
    output logic [LINE_WORDS*32-1:0] fill_data,
    input  logic                     fill_ack
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] nxt_idx;

    // Slot index wraps naturally through the IDX_W-bit adder.
    assign cur_idx = start_idx + count;
    assign nxt_idx = cur_idx + 1'b1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            start_idx  <= '0;
            count      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            crit_valid <= 1'b0;
            crit_word  <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
        end else begin
            mem_req    <= 1'b0;
            crit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        fill_addr <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        start_idx <= miss_addr[OFF_W-1:2];
                        count     <= '0;
                        // mem_req is raised on entry so it is high exactly while in REQ
                        mem_addr  <= {miss_addr[ADDR_W-1:2], 2'b00};
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    if (mem_rvalid) begin
                        fill_data[32*cur_idx +: 32] <= mem_rdata;
                        if (count == '0) begin
                            crit_valid <= 1'b1;
                            crit_word  <= mem_rdata;
                        end
                        if (count == IDX_W'(LINE_WORDS-1)) begin
                            fill_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            count    <= count + 1'b1;
                            mem_addr <= {fill_addr[ADDR_W-1:OFF_W], nxt_idx, 2'b00};
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                DONE: begin
                    if (fill_ack) begin
                        fill_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
